// File: rtl/soft_clock_mc.sv
// soft_clock_mc: IPIF-programmed, glitch-free gating of C_NUM_CLK clocks derived from Bus2IP_Clk.
// IPIF MSB-first bit j maps to vector bit N-1-j here, so every field below uses the descending view.
module soft_clock_mc #(
  parameter int                   C_SIPIF_DWIDTH = 32,
  parameter int                   C_NUM_CLK      = 4,
  parameter int                   C_CNT_WIDTH    = 8,
  parameter logic [C_NUM_CLK-1:0] C_RESET_ON     = 4'hF
) (
  input  logic                        Bus2IP_Clk,
  input  logic                        Bus2IP_Reset,
  input  logic                        Bus2IP_WrCE,
  input  logic                        Bus2IP_RdCE,
  input  logic [C_SIPIF_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SIPIF_DWIDTH/8-1:0] Bus2IP_BE,
  output logic [C_NUM_CLK-1:0]        Clk2IP_Clk,
  output logic [C_SIPIF_DWIDTH-1:0]   Clk2Bus_Data,
  output logic                        Clk2Bus_WrAck,
  output logic                        Clk2Bus_RdAck,
  output logic                        Clk2Bus_Error,
  output logic                        Clk2Bus_ToutSup
);

  localparam int N = C_SIPIF_DWIDTH;

  localparam logic [3:0] OP_ENABLE  = 4'b1010;
  localparam logic [3:0] OP_DISABLE = 4'b0101;
  localparam logic [3:0] OP_RUN     = 4'b1100;

  localparam logic [1:0] ST_OFF = 2'b00;
  localparam logic [1:0] ST_ON  = 2'b01;
  localparam logic [1:0] ST_RUN = 2'b10;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ZERO = {C_CNT_WIDTH{1'b0}};
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]             op_s;
  logic [C_NUM_CLK-1:0]   mask_s;
  logic [C_CNT_WIDTH-1:0] cnt_s;
  logic                   lane_s;
  logic                   legal_s;
  logic                   valid_s;
  logic                   wr_go_s;
  logic [C_NUM_CLK-1:0]   on_s;
  logic [C_NUM_CLK-1:0]   run_s;
  logic                   unused_s;

  // Command decode and write qualification
  always_comb begin
    op_s   = Bus2IP_Data[3:0];
    mask_s = Bus2IP_Data[4 +: C_NUM_CLK];
    cnt_s  = Bus2IP_Data[N-1 -: C_CNT_WIDTH];
    lane_s = Bus2IP_WrCE & Bus2IP_BE[0];
    case (op_s)
      OP_ENABLE, OP_DISABLE: legal_s = 1'b1;
      OP_RUN:                legal_s = (cnt_s != CNT_ZERO);
      default:               legal_s = 1'b0;
    endcase
    valid_s = legal_s & (|mask_s);
  end

  assign Clk2Bus_WrAck   = lane_s & valid_s;
  assign Clk2Bus_Error   = lane_s & ~valid_s;
  assign Clk2Bus_RdAck   = Bus2IP_RdCE;
  assign Clk2Bus_ToutSup = Bus2IP_Reset;
  assign wr_go_s         = lane_s & valid_s;
  assign unused_s        = ^{Bus2IP_Data, Bus2IP_BE};

  for (genvar g = 0; g < C_NUM_CLK; g++) begin : g_ch
    localparam logic [1:0] ST_RST = C_RESET_ON[g] ? ST_ON : ST_OFF;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [C_CNT_WIDTH-1:0] cnt_q;
    logic [C_CNT_WIDTH-1:0] cnt_d;
    logic                   en_pos_q;
    logic                   en_neg_q;

    // Next state: a selecting write always wins, otherwise a RUN counts down to OFF
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (wr_go_s && mask_s[g]) begin
        case (op_s)
          OP_ENABLE:  state_d = ST_ON;
          OP_DISABLE: state_d = ST_OFF;
          OP_RUN: begin
            state_d = ST_RUN;
            cnt_d   = cnt_s;
          end
          default:    state_d = state_q;
        endcase
      end else begin
        case (state_q)
          ST_RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_RUN;
            end
          end
          ST_ON:   state_d = ST_ON;
          ST_OFF:  state_d = ST_OFF;
          default: state_d = ST_OFF;
        endcase
      end
    end

    // Channel state, count and rising-edge enable
    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
        state_q  <= ST_RST;
        cnt_q    <= CNT_ZERO;
        en_pos_q <= C_RESET_ON[g];
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        en_pos_q <= (state_d != ST_OFF);
      end
    end

    // Retime the enable into the low phase so the AND gate never cuts a high pulse
    always_ff @(negedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
        en_neg_q <= C_RESET_ON[g];
      end else begin
        en_neg_q <= en_pos_q;
      end
    end

    assign Clk2IP_Clk[g] = Bus2IP_Clk & en_neg_q;
    assign on_s[g]       = (state_q != ST_OFF);
    assign run_s[g]      = (state_q == ST_RUN);
  end

  // Status word reflects registered state, so a same-cycle write is not yet visible
  always_comb begin
    Clk2Bus_Data = {N{1'b0}};
    if (Bus2IP_RdCE) begin
      Clk2Bus_Data[C_NUM_CLK-1:0]           = on_s;
      Clk2Bus_Data[2*C_NUM_CLK-1:C_NUM_CLK] = run_s;
    end else begin
      Clk2Bus_Data = {N{1'b0}};
    end
  end

endmodule

// File: tb/tb_soft_clock_mc.sv
// Randomized self-checking bench for soft_clock_mc against a per-channel on/remaining-count model.
module tb_soft_clock_mc;

  localparam logic [3:0] OP_EN  = 4'hA;
  localparam logic [3:0] OP_DIS = 4'h5;
  localparam logic [3:0] OP_RUN = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrce;
  logic        rdce;
  logic [31:0] data;
  logic [3:0]  be;
  logic [3:0]  gclk;
  logic [31:0] rdata;
  logic        wrack;
  logic        rdack;
  logic        err;
  logic        tout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: channel is "on" forever, or running with m_rem edges left (m_rem > 0)
  bit m_on[4];
  int m_rem[4];

  soft_clock_mc dut (
    .Bus2IP_Clk      (clk),
    .Bus2IP_Reset    (rst),
    .Bus2IP_WrCE     (wrce),
    .Bus2IP_RdCE     (rdce),
    .Bus2IP_Data     (data),
    .Bus2IP_BE       (be),
    .Clk2IP_Clk      (gclk),
    .Clk2Bus_Data    (rdata),
    .Clk2Bus_WrAck   (wrack),
    .Clk2Bus_RdAck   (rdack),
    .Clk2Bus_Error   (err),
    .Clk2Bus_ToutSup (tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_valid(input logic [31:0] d);
    bit legal;
    legal = (d[3:0] == OP_EN) || (d[3:0] == OP_DIS) || (d[3:0] == OP_RUN && d[31:24] != 8'd0);
    return legal && (d[7:4] != 4'd0);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < 4; i++) begin
      s[i]     = m_on[i] || (m_rem[i] > 0);
      s[4 + i] = (m_rem[i] > 0);
    end
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_on[i]  = 1'b1;
      m_rem[i] = 0;
    end
  endtask

  // One bus cycle: drive, check combinational response, then check the gated edge that follows
  task automatic cyc(input logic wr, input logic rd, input logic [31:0] d, input logic [3:0] b);
    logic        lane;
    logic        ok;
    logic [31:0] exp_clk;
    wrce = wr;
    rdce = rd;
    data = d;
    be   = b;
    #1;
    lane = wr & b[0];
    ok   = m_valid(d);
    chk("wrack", {31'd0, wrack}, {31'd0, lane & ok});
    chk("error", {31'd0, err}, {31'd0, lane & ~ok});
    chk("rdack", {31'd0, rdack}, {31'd0, rd});
    chk("rdata", rdata, rd ? m_status() : 32'h0);
    chk("toutsup", {31'd0, tout}, 32'd0);
    @(posedge clk);
    #1;
    exp_clk = {28'd0, m_status() [3:0]};
    chk("gclk_rise", {28'd0, gclk}, exp_clk);
    for (int i = 0; i < 4; i++) begin
      if (lane && ok && d[4 + i]) begin
        case (d[3:0])
          OP_EN:   begin m_on[i] = 1'b1; m_rem[i] = 0; end
          OP_DIS:  begin m_on[i] = 1'b0; m_rem[i] = 0; end
          default: begin m_on[i] = 1'b0; m_rem[i] = int'(d[31:24]); end
        endcase
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
      end
    end
    #2;
    chk("gclk_high", {28'd0, gclk}, exp_clk);
    wrce = 1'b0;
    rdce = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 32'h0, 4'hF);
  endtask

  // Asynchronous reset pulse taken either in the high or low phase of Bus2IP_Clk
  task automatic do_reset(input bit high_phase);
    wrce = 1'b0;
    rdce = 1'b1;
    data = 32'h0;
    be   = 4'h0;
    if (!high_phase) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_gclk", {28'd0, gclk}, high_phase ? 32'hF : 32'h0);
    chk("rst_tout", {31'd0, tout}, 32'd1);
    chk("rst_status", rdata, 32'h0000000F);
    @(posedge clk);
    #1;
    chk("rst_hold_gclk", {28'd0, gclk}, 32'hF);
    @(negedge clk);
    #1;
    rst  = 1'b0;
    rdce = 1'b0;
    m_reset();
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  op;
    rst  = 1'b1;
    wrce = 1'b0;
    rdce = 1'b0;
    data = 32'h0;
    be   = 4'h0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;

    // Reset state and first status read
    cyc(1'b0, 1'b1, 32'h0, 4'hF);
    // Disable ch1
    cyc(1'b1, 1'b0, 32'h00000025, 4'hF);
    idle(3);
    // RUN 3 on ch2
    cyc(1'b1, 1'b0, 32'h0300004C, 4'hF);
    idle(5);
    // Rejected writes and ignored lane
    cyc(1'b1, 1'b0, 32'h00000017, 4'hF);
    cyc(1'b1, 1'b0, 32'h0000000A, 4'hF);
    cyc(1'b1, 1'b0, 32'h000000FC, 4'hF);
    cyc(1'b1, 1'b0, 32'h00000015, 4'hE);
    idle(1);
    // Read and write together: read sees pre-write state
    cyc(1'b1, 1'b1, 32'h000000F5, 4'hF);
    idle(2);
    // RUN 10 on ch0 overridden by ENABLE at the 4th pulse, then a RUN cut by DISABLE
    cyc(1'b1, 1'b0, 32'h0A00001C, 4'hF);
    idle(3);
    cyc(1'b1, 1'b0, 32'h0000001A, 4'hF);
    idle(12);
    cyc(1'b1, 1'b0, 32'h0A00001C, 4'hF);
    idle(2);
    cyc(1'b1, 1'b0, 32'h00000015, 4'hF);
    idle(3);
    // Reset mid-RUN in the high phase, then again in the low phase
    cyc(1'b1, 1'b0, 32'h0000001A, 4'hF);
    cyc(1'b1, 1'b0, 32'h000000A5, 4'hF);
    cyc(1'b1, 1'b0, 32'h0A00004C, 4'hF);
    idle(2);
    do_reset(1'b1);
    idle(1);
    cyc(1'b1, 1'b0, 32'h000000F5, 4'hF);
    cyc(1'b1, 1'b0, 32'h0A00004C, 4'hF);
    idle(2);
    do_reset(1'b0);
    idle(2);

    // Randomized traffic, with middle bits of the command word as junk
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_EN;
        1:       op = OP_DIS;
        2:       op = OP_RUN;
        default: op = 4'($urandom_range(0, 15));
      endcase
      d = {8'($urandom_range(0, 12)), 16'($urandom), 4'($urandom_range(0, 15)), op};
      if ($urandom_range(0, 149) == 0) do_reset(1'($urandom_range(0, 1)));
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), d,
          ($urandom_range(0, 5) == 0) ? 4'hE : 4'hF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
